// File: rtl/reset_seq_ctrl.sv
// rtl/reset_seq_ctrl.sv - staged active-low reset release sequencer for multiple clock-reset domains
module reset_seq_ctrl #(
    parameter int NUM_DOMAINS = 3,
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ext_hold,
    input  logic                   sw_rst_req,
    output logic [NUM_DOMAINS-1:0] n_rst_out,
    output logic                   seq_done,
    output logic                   sw_rst_ack
);

    // Counter must reach the larger of the two terminal counts.
    localparam int MAX_CYCLES = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
    localparam int IDX_W      = $clog2(NUM_DOMAINS + 1);

    localparam logic [CNT_W-1:0]       HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]       GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [IDX_W-1:0]       IDX_LAST  = IDX_W'(NUM_DOMAINS - 1);
    localparam logic [NUM_DOMAINS-1:0] BIT0      = NUM_DOMAINS'(1);

    typedef enum logic [1:0] {
        HOLD    = 2'd0,
        RELEASE = 2'd1,
        RUN     = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] idx;
    // Remembers that the current re-sequence was software requested, so that
    // exactly one ack is issued when it eventually reaches RUN.
    logic             pending;

    // Sequencer: abort handling first, then hold count, staged release, run.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= HOLD;
            cnt        <= '0;
            idx        <= '0;
            n_rst_out  <= '0;
            seq_done   <= 1'b0;
            sw_rst_ack <= 1'b0;
            pending    <= 1'b0;
        end else begin
            sw_rst_ack <= 1'b0;
            // Abort wins over any release that would happen on this edge.
            if (ext_hold || sw_rst_req) begin
                state     <= HOLD;
                cnt       <= '0;
                idx       <= '0;
                n_rst_out <= '0;
                seq_done  <= 1'b0;
                if (sw_rst_req) begin
                    pending <= 1'b1;
                end
            end else begin
                case (state)
                    HOLD: begin
                        if (cnt == HOLD_LAST) begin
                            n_rst_out[0] <= 1'b1;
                            cnt          <= '0;
                            if (NUM_DOMAINS == 1) begin
                                state      <= RUN;
                                seq_done   <= 1'b1;
                                sw_rst_ack <= pending;
                                pending    <= 1'b0;
                            end else begin
                                idx   <= IDX_W'(1);
                                state <= RELEASE;
                            end
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    RELEASE: begin
                        if (cnt == GAP_LAST) begin
                            // OR-in keeps earlier domains released; idx only
                            // moves upward so release order is fixed.
                            n_rst_out <= n_rst_out | (BIT0 << idx);
                            cnt       <= '0;
                            if (idx == IDX_LAST) begin
                                state      <= RUN;
                                seq_done   <= 1'b1;
                                sw_rst_ack <= pending;
                                pending    <= 1'b0;
                            end else begin
                                idx <= idx + IDX_W'(1);
                            end
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    RUN: begin
                        state <= RUN;
                    end
                    default: begin
                        state     <= HOLD;
                        cnt       <= '0;
                        idx       <= '0;
                        n_rst_out <= '0;
                        seq_done  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_reset_seq_ctrl.sv
// tb/tb_reset_seq_ctrl.sv - directed self-checking bench for reset_seq_ctrl
module tb_reset_seq_ctrl;

    logic       clk;
    logic       rst;
    logic       ext_hold;
    logic       sw_rst_req;
    logic [2:0] n_rst_out;
    logic       seq_done;
    logic       sw_rst_ack;
    logic [0:0] n_rst_out1;
    logic       seq_done1;
    logic       sw_rst_ack1;

    int checks = 0;
    int passes = 0;

    reset_seq_ctrl #(.NUM_DOMAINS(3), .HOLD_CYCLES(4), .GAP_CYCLES(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .ext_hold   (ext_hold),
        .sw_rst_req (sw_rst_req),
        .n_rst_out  (n_rst_out),
        .seq_done   (seq_done),
        .sw_rst_ack (sw_rst_ack)
    );

    reset_seq_ctrl #(.NUM_DOMAINS(1), .HOLD_CYCLES(1), .GAP_CYCLES(5)) dut1 (
        .clk        (clk),
        .rst        (rst),
        .ext_hold   (ext_hold),
        .sw_rst_req (sw_rst_req),
        .n_rst_out  (n_rst_out1),
        .seq_done   (seq_done1),
        .sw_rst_ack (sw_rst_ack1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) begin
            passes++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Edge t counted from the start of a sequence: releases at 4, 6, 8.
    function automatic logic [2:0] exp_n(input int t);
        if (t >= 8)      return 3'b111;
        else if (t >= 6) return 3'b011;
        else if (t >= 4) return 3'b001;
        else             return 3'b000;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input string tag, input int t, input logic ack_exp);
        tick();
        chk({tag, ".n_rst"}, {29'd0, n_rst_out}, {29'd0, exp_n(t)});
        chk({tag, ".done"},  {31'd0, seq_done}, {31'd0, (t >= 8)});
        chk({tag, ".ack"},   {31'd0, sw_rst_ack}, {31'd0, ack_exp});
    endtask

    initial begin
        rst        = 1'b1;
        ext_hold   = 1'b0;
        sw_rst_req = 1'b0;
        repeat (2) tick();
        chk("reset.n_rst", {29'd0, n_rst_out}, 32'd0);
        chk("reset.done",  {31'd0, seq_done}, 32'd0);
        chk("reset.ack",   {31'd0, sw_rst_ack}, 32'd0);
        chk("reset1.n_rst", {31'd0, n_rst_out1}, 32'd0);
        chk("reset1.done",  {31'd0, seq_done1}, 32'd0);
        rst = 1'b0;

        // Power-on sequence; single-domain instance releases on edge 1.
        for (int t = 1; t <= 9; t++) begin
            step("por", t, 1'b0);
            chk("por1.n_rst", {31'd0, n_rst_out1}, 32'd1);
            chk("por1.done",  {31'd0, seq_done1}, 32'd1);
            chk("por1.ack",   {31'd0, sw_rst_ack1}, 32'd0);
        end

        // ext_hold high for edges 1..10 after reset.
        rst      = 1'b1;
        ext_hold = 1'b1;
        tick();
        rst = 1'b0;
        for (int e = 1; e <= 20; e++) begin
            ext_hold = (e <= 10);
            step("hold", e - 10, 1'b0);
        end
        ext_hold = 1'b0;

        // Software re-sequence from RUN, ack at the final release only.
        sw_rst_req = 1'b1;
        step("sw", 0, 1'b0);
        sw_rst_req = 1'b0;
        for (int t = 1; t <= 9; t++) step("sw", t, (t == 8));

        // Request lands on the edge that would release domain 2.
        sw_rst_req = 1'b1;
        step("abort", 0, 1'b0);
        sw_rst_req = 1'b0;
        for (int t = 1; t <= 7; t++) step("abort", t, 1'b0);
        sw_rst_req = 1'b1;
        step("abort.d2", 0, 1'b0);
        sw_rst_req = 1'b0;
        for (int t = 1; t <= 10; t++) step("abort.re", t, (t == 8));

        // Async reset mid-RELEASE clears outputs before any clock edge and
        // drops the pending ack.
        sw_rst_req = 1'b1;
        step("async", 0, 1'b0);
        sw_rst_req = 1'b0;
        for (int t = 1; t <= 6; t++) step("async", t, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("async.n_rst", {29'd0, n_rst_out}, 32'd0);
        chk("async.done",  {31'd0, seq_done}, 32'd0);
        #1;
        rst = 1'b0;
        for (int t = 1; t <= 10; t++) step("async.re", t, 1'b0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
